// File: rtl/sap_ctrl_pkg.sv
// rtl/sap_ctrl_pkg.sv - opcodes, T-state encodings and control-word layout for the SAP sequencer
package sap_ctrl_pkg;

    localparam int T_STATES = 6;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [5:0] T_NONE = 6'b000000;
    localparam logic [5:0] T_T1   = 6'b000001;
    localparam logic [5:0] T_T2   = 6'b000010;
    localparam logic [5:0] T_T3   = 6'b000100;
    localparam logic [5:0] T_T4   = 6'b001000;
    localparam logic [5:0] T_T5   = 6'b010000;
    localparam logic [5:0] T_T6   = 6'b100000;

    // Bit positions in the packed control bus handed to the CPU top.
    localparam int CW_PC_INC   = 0;
    localparam int CW_PC_OUT   = 1;
    localparam int CW_MAR_LOAD = 2;
    localparam int CW_RAM_OUT  = 3;
    localparam int CW_IR_LOAD  = 4;
    localparam int CW_IR_OUT   = 5;
    localparam int CW_A_LOAD   = 6;
    localparam int CW_A_OUT    = 7;
    localparam int CW_B_LOAD   = 8;
    localparam int CW_ALU_SUB  = 9;
    localparam int CW_ALU_OUT  = 10;
    localparam int CW_OUT_LOAD = 11;
    localparam int CW_HALT     = 12;
    localparam int CW_WIDTH    = 13;

    typedef logic [CW_WIDTH-1:0] ctrl_word_t;

    function automatic ctrl_word_t cw_bit(input int idx);
        return ctrl_word_t'(1) << idx;
    endfunction

    // Enables that change register contents; these are masked while the clock is paused.
    localparam ctrl_word_t CW_LOAD_MASK = cw_bit(CW_PC_INC) | cw_bit(CW_MAR_LOAD)
                                        | cw_bit(CW_IR_LOAD) | cw_bit(CW_A_LOAD)
                                        | cw_bit(CW_B_LOAD) | cw_bit(CW_OUT_LOAD);

endpackage

// File: rtl/ring_counter_6.sv
// rtl/ring_counter_6.sv - six-phase one-hot ring counter with enable and synchronous clear
module ring_counter_6
    import sap_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable_i,
    input  logic       halt_clear_i,
    output logic [5:0] t_state_o
);

    logic [5:0] state_q;
    logic [5:0] state_d;

    always_comb begin
        state_d = state_q;
        if (halt_clear_i) begin
            state_d = T_NONE;
        end else if (enable_i) begin
            state_d = {state_q[4:0], state_q[5]};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= T_T1;
        end else begin
            state_q <= state_d;
        end
    end

    assign t_state_o = state_q;

endmodule

// File: rtl/sap_control_sequencer.sv
// rtl/sap_control_sequencer.sv - T-state ring plus opcode decode into the SAP control word
module sap_control_sequencer
    import sap_ctrl_pkg::*;
#(
    parameter int T_STATES = 6
) (
    input  logic                clock,
    input  logic                input_reset_n,
    input  logic                input_run,
    input  logic [3:0]          input_opcode,
    output logic [T_STATES-1:0] output_t_state,
    output logic                output_pc_inc,
    output logic                output_pc_out,
    output logic                output_mar_load,
    output logic                output_ram_out,
    output logic                output_ir_load,
    output logic                output_ir_out,
    output logic                output_a_load,
    output logic                output_a_out,
    output logic                output_b_load,
    output logic                output_alu_sub,
    output logic                output_alu_out,
    output logic                output_out_load,
    output logic                output_halt
);

    logic [T_STATES-1:0] t_state;
    logic                halt_q;
    logic                halt_d;
    logic                halt_enter;
    ctrl_word_t          cw_decode;
    ctrl_word_t          cw_final;

    assign halt_enter = input_run && (t_state == T_T4) && (input_opcode == OP_HLT);
    assign halt_d     = halt_q | halt_enter;

    ring_counter_6 u_ring (
        .clock        (clock),
        .reset_n      (input_reset_n),
        .enable_i     (input_run && !halt_q),
        .halt_clear_i (halt_enter || halt_q),
        .t_state_o    (t_state)
    );

    always_ff @(posedge clock or negedge input_reset_n) begin
        if (!input_reset_n) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    always_comb begin
        cw_decode = '0;
        casez ({t_state, input_opcode})
            {T_T1, 4'b????}: cw_decode = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_LOAD);
            {T_T2, 4'b????}: cw_decode = cw_bit(CW_PC_INC);
            {T_T3, 4'b????}: cw_decode = cw_bit(CW_RAM_OUT) | cw_bit(CW_IR_LOAD);
            {T_T4, OP_LDA},
            {T_T4, OP_ADD},
            {T_T4, OP_SUB}:  cw_decode = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_LOAD);
            {T_T5, OP_LDA}:  cw_decode = cw_bit(CW_RAM_OUT) | cw_bit(CW_A_LOAD);
            {T_T5, OP_ADD}:  cw_decode = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_LOAD);
            {T_T5, OP_SUB}:  cw_decode = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_LOAD)
                                       | cw_bit(CW_ALU_SUB);
            {T_T6, OP_ADD}:  cw_decode = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_LOAD);
            {T_T6, OP_SUB}:  cw_decode = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_LOAD)
                                       | cw_bit(CW_ALU_SUB);
            {T_T4, OP_OUT}:  cw_decode = cw_bit(CW_A_OUT) | cw_bit(CW_OUT_LOAD);
            {T_T4, OP_HLT}:  cw_decode = cw_bit(CW_HALT);
            default:         cw_decode = '0;
        endcase
    end

    // Paused clock keeps bus enables visible but blocks every state-changing load.
    always_comb begin
        cw_final = cw_decode;
        if (!input_run) begin
            cw_final = cw_decode & ~CW_LOAD_MASK;
        end
        if (halt_q) begin
            cw_final = cw_bit(CW_HALT);
        end
    end

    assign output_t_state  = t_state;
    assign output_pc_inc   = cw_final[CW_PC_INC];
    assign output_pc_out   = cw_final[CW_PC_OUT];
    assign output_mar_load = cw_final[CW_MAR_LOAD];
    assign output_ram_out  = cw_final[CW_RAM_OUT];
    assign output_ir_load  = cw_final[CW_IR_LOAD];
    assign output_ir_out   = cw_final[CW_IR_OUT];
    assign output_a_load   = cw_final[CW_A_LOAD];
    assign output_a_out    = cw_final[CW_A_OUT];
    assign output_b_load   = cw_final[CW_B_LOAD];
    assign output_alu_sub  = cw_final[CW_ALU_SUB];
    assign output_alu_out  = cw_final[CW_ALU_OUT];
    assign output_out_load = cw_final[CW_OUT_LOAD];
    assign output_halt     = cw_final[CW_HALT];

endmodule

// File: tb/tb_sap_control_sequencer.sv
// tb/tb_sap_control_sequencer.sv - directed self-checking bench for sap_control_sequencer
module tb_sap_control_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       run;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out;
    logic a_load, a_out, b_load, alu_sub, alu_out, out_load, halt;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sap_control_sequencer #(.T_STATES(6)) dut (
        .clock           (clock),
        .input_reset_n   (reset_n),
        .input_run       (run),
        .input_opcode    (opcode),
        .output_t_state  (t_state),
        .output_pc_inc   (pc_inc),
        .output_pc_out   (pc_out),
        .output_mar_load (mar_load),
        .output_ram_out  (ram_out),
        .output_ir_load  (ir_load),
        .output_ir_out   (ir_out),
        .output_a_load   (a_load),
        .output_a_out    (a_out),
        .output_b_load   (b_load),
        .output_alu_sub  (alu_sub),
        .output_alu_out  (alu_out),
        .output_out_load (out_load),
        .output_halt     (halt)
    );

    // bit 0 pc_inc .. bit 12 halt
    wire [12:0] cw_obs = {halt, out_load, alu_out, alu_sub, b_load, a_out, a_load,
                          ir_out, ir_load, ram_out, mar_load, pc_out, pc_inc};

    task automatic tick;
        @(posedge clock);
        #3;
    endtask

    task automatic test_reset;
        logic [5:0] exp_seq [6];
        exp_seq = '{6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b000001};
        reset_n = 1'b0;
        run     = 1'b1;
        opcode  = 4'b0000;
        #7;
        checks++;
        if (t_state !== 6'b000001) begin
            errors++;
            $display("FAIL reset_tstate: got %b want 000001", t_state);
        end
        checks++;
        if (cw_obs !== 13'h0006) begin
            errors++;
            $display("FAIL reset_cw: got %h want 0006", cw_obs);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (t_state !== exp_seq[i]) begin
                errors++;
                $display("FAIL reset_seq%0d: got %b want %b", i, t_state, exp_seq[i]);
            end
        end
    endtask

    task automatic test_instr(input string name, input logic [3:0] op,
                              input logic [12:0] e4, input logic [12:0] e5,
                              input logic [12:0] e6);
        logic [12:0] exp_cw [6];
        logic [5:0]  exp_t  [6];
        exp_cw = '{13'h0006, 13'h0001, 13'h0018, e4, e5, e6};
        exp_t  = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000};
        opcode = op;
        run    = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (t_state !== exp_t[i] || cw_obs !== exp_cw[i]) begin
                errors++;
                $display("FAIL %s_T%0d: got t=%b cw=%h want t=%b cw=%h",
                         name, i + 1, t_state, cw_obs, exp_t[i], exp_cw[i]);
            end
            tick();
        end
        checks++;
        if (t_state !== 6'b000001) begin
            errors++;
            $display("FAIL %s_wrap: got %b want 000001", name, t_state);
        end
    endtask

    task automatic test_hlt;
        logic [12:0] exp_cw [4];
        exp_cw = '{13'h0006, 13'h0001, 13'h0018, 13'h1000};
        opcode = 4'b1111;
        run    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (cw_obs !== exp_cw[i]) begin
                errors++;
                $display("FAIL hlt_T%0d: got cw=%h want %h", i + 1, cw_obs, exp_cw[i]);
            end
            tick();
        end
        for (int i = 0; i < 21; i++) begin
            if (i == 5) opcode = 4'b0000;
            #1;
            checks++;
            if (t_state !== 6'b000000 || cw_obs !== 13'h1000) begin
                errors++;
                $display("FAIL halted%0d: got t=%b cw=%h want t=000000 cw=1000",
                         i, t_state, cw_obs);
            end
            tick();
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (t_state !== 6'b000001 || halt !== 1'b0 || cw_obs !== 13'h0006) begin
            errors++;
            $display("FAIL hlt_reset: got t=%b cw=%h want t=000001 cw=0006", t_state, cw_obs);
        end
        tick();
        reset_n = 1'b1;
        #1;
        checks++;
        if (t_state !== 6'b000001) begin
            errors++;
            $display("FAIL hlt_release: got %b want 000001", t_state);
        end
    endtask

    task automatic test_freeze;
        opcode = 4'b0000;
        run    = 1'b0;
        #1;
        checks++;
        if (cw_obs !== 13'h0002) begin
            errors++;
            $display("FAIL freeze_T1_cw: got %h want 0002", cw_obs);
        end
        tick();
        checks++;
        if (t_state !== 6'b000001) begin
            errors++;
            $display("FAIL freeze_T1_hold: got %b want 000001", t_state);
        end
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (t_state !== 6'b000010 || pc_inc !== 1'b0) begin
                errors++;
                $display("FAIL freeze_T2_%0d: got t=%b pc_inc=%b want t=000010 pc_inc=0",
                         i, t_state, pc_inc);
            end
            tick();
        end
        run = 1'b1;
        #1;
        checks++;
        if (t_state !== 6'b000010 || pc_inc !== 1'b1) begin
            errors++;
            $display("FAIL unfreeze: got t=%b pc_inc=%b want t=000010 pc_inc=1", t_state, pc_inc);
        end
        tick();
        checks++;
        if (t_state !== 6'b000100 || pc_inc !== 1'b0) begin
            errors++;
            $display("FAIL unfreeze_T3: got t=%b pc_inc=%b want t=000100 pc_inc=0",
                     t_state, pc_inc);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (t_state !== 6'b000001) begin
            errors++;
            $display("FAIL freeze_wrap: got %b want 000001", t_state);
        end
    endtask

    task automatic test_invariants;
        int ms = 0;
        int drivers;
        bit defined_op;
        for (int i = 0; i < 500; i++) begin
            opcode = (i % 37 == 0) ? 4'b0101 : 4'($urandom_range(0, 14));
            run    = ($urandom_range(0, 3) != 0);
            #1;
            drivers = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out);
            defined_op = (opcode == 4'b0000) || (opcode == 4'b0001) ||
                         (opcode == 4'b0010) || (opcode == 4'b1110);
            checks++;
            if (t_state !== (6'b000001 << ms)) begin
                errors++;
                $display("FAIL inv_tstate%0d: got %b want %b", i, t_state, 6'b000001 << ms);
            end
            checks++;
            if (drivers > 1 || !$onehot(t_state)) begin
                errors++;
                $display("FAIL inv_bus%0d: got drivers=%0d t=%b want <=1 and onehot",
                         i, drivers, t_state);
            end
            if (ms >= 3 && !defined_op) begin
                checks++;
                if (cw_obs !== 13'h0000) begin
                    errors++;
                    $display("FAIL inv_nop%0d: got cw=%h want 0000 op=%b", i, cw_obs, opcode);
                end
            end
            if (!run) begin
                checks++;
                if ((cw_obs & 13'h0955) !== 13'h0000) begin
                    errors++;
                    $display("FAIL inv_mask%0d: got cw=%h want loads 0", i, cw_obs);
                end
            end
            tick();
            if (run) ms = (ms + 1) % 6;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        run     = 1'b0;
        opcode  = 4'b0000;
        test_reset();
        test_instr("lda", 4'b0000, 13'h0024, 13'h0048, 13'h0000);
        test_instr("add", 4'b0001, 13'h0024, 13'h0108, 13'h0440);
        test_instr("sub", 4'b0010, 13'h0024, 13'h0308, 13'h0640);
        test_instr("out", 4'b1110, 13'h0880, 13'h0000, 13'h0000);
        test_instr("nop", 4'b0101, 13'h0000, 13'h0000, 13'h0000);
        test_instr("lda2", 4'b0000, 13'h0024, 13'h0048, 13'h0000);
        test_freeze();
        test_hlt();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sap_control_sequencer.md
# sap_control_sequencer

Control sequencer for the 8-bit CPU. A six-phase one-hot ring counter (T1–T6) is decoded together with the instruction-register opcode into the per-cycle control word. That control word drives the `clock_enable` / load inputs of the 4-bit and 8-bit registers (PC, MAR, IR, A, B, OUT) and the bus output enables. The block sits directly upstream of every register: each register samples its enable from this block on the next rising `clock`.

## Interface
Parameters:
- `T_STATES`, 6: ring length; fixed at 6, and other values are unsupported.

Ports:
- `clock`  in  1: system clock; all state changes on the rising edge.
- `input_reset_n`  in  1: reset, asynchronous and active-low; forces state to T1 and clears halt.
- `input_run`  in  1: high means advance one T-state per clock; low means freeze state and mask all load/increment enables.
- `input_opcode`  in  4: IR upper nibble; decoded only in T4–T6.
- `output_t_state`  out  6: one-hot current T-state, where bit 0 is T1; all-zero while halted.
- `output_pc_inc`  out  1: PC count enable (Cp).
- `output_pc_out`  out  1: PC drives bus (Ep).
- `output_mar_load`  out  1: MAR load (Lm).
- `output_ram_out`  out  1: RAM drives bus (CE).
- `output_ir_load`  out  1: IR load (Li).
- `output_ir_out`  out  1: IR low nibble drives bus (Ei).
- `output_a_load`  out  1: accumulator load (La).
- `output_a_out`  out  1: accumulator drives bus (Ea).
- `output_b_load`  out  1: B register load (Lb).
- `output_alu_sub`  out  1: ALU subtract select (Su).
- `output_alu_out`  out  1: ALU drives bus (Eu).
- `output_out_load`  out  1: output register load (Lo).
- `output_halt`  out  1: CPU halted.

## Operation
- Opcodes: LDA=0000, ADD=0001, SUB=0010, OUT=1110, HLT=1111. Any other opcode is a NOP, with T4–T6 all-zero.
- Fetch, for every opcode:
  - T1: pc_out, mar_load.
  - T2: pc_inc.
  - T3: ram_out, ir_load.
- LDA:
  - T4: ir_out, mar_load.
  - T5: ram_out, a_load.
  - T6: none.
- ADD:
  - T4: ir_out, mar_load.
  - T5: ram_out, b_load.
  - T6: alu_out, a_load.
- SUB: same as ADD, plus alu_sub in T5 and T6.
- OUT:
  - T4: a_out, out_load.
  - T5–T6: none.
- HLT:
  - T4: output_halt=1, all other control outputs 0.
  - The next rising edge with input_run=1 enters HALT.
- HALT state:
  - output_t_state=0, all control outputs 0, output_halt=1.
  - Left only by reset.
- input_run=0:
  - State holds.
  - pc_inc, mar_load, ir_load, a_load, b_load and out_load are forced 0.
  - Bus enables and alu_sub still follow decode.
- Control outputs are combinational from state and opcode; there are no registered outputs.
- At most one bus driver is asserted in any T-state; verification checks this as an invariant.

## Timing
- Reset value, asynchronous and immediate:
  - State = T1, output_t_state=000001.
  - output_pc_out=1, output_mar_load=1, all other outputs 0, halted flag cleared.
- Transitions:
  - T1→T2→…→T6→T1 on each rising edge with input_run=1.
  - HLT is the exception: T4→HALT.
- Instruction latency: a fixed 6 clocks per instruction; HLT reaches HALT 4 clocks after its T1.
- input_opcode must be stable from the edge that ends T3 through the end of T6. A change mid-T4..T6 changes decode in the same cycle, and no latching is performed.
- Reset asserted mid-instruction aborts it; the sequence restarts at T1 after deassertion.
- Deasserting reset starts the sequence as follows:
  - The first rising edge after deassertion with input_run=1 moves to T2.
  - Reset release is assumed synchronised externally.
- input_run toggling:
  - The state after re-enable equals the state before freeze.
  - No T-state is skipped or repeated beyond the frozen cycles.

## Structure
- Package `sap_ctrl_pkg` holds:
  - opcode localparams (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT);
  - T-state one-hot constants;
  - control-word bit indices, so the CPU top can build a packed control bus.
- Sub-module `ring_counter_6`:
  - one-hot shift register with async active-low reset to 000001, enable and synchronous halt-clear to 000000;
  - the halt flip-flop lives in `sap_control_sequencer`.
- The decoder is a single combinational case on the {state, opcode} pair in the top module.

## Test plan
- Reset:
  - Hold input_reset_n=0 → t_state=000001, pc_out=1, mar_load=1, all else 0.
  - Release with run=1 → t_state steps 000010, 000100, … 100000, 000001 over 6 clocks.
- LDA (opcode 0000):
  - T4 → ir_out=1, mar_load=1.
  - T5 → ram_out=1, a_load=1.
  - T6 → all 0.
- SUB (opcode 0010):
  - T5 → ram_out=1, b_load=1, alu_sub=1.
  - T6 → alu_out=1, a_load=1, alu_sub=1.
  - ADD (0001) gives identical outputs with alu_sub=0.
- HLT (opcode 1111):
  - T4 → halt=1.
  - Next edge → t_state=000000, halt=1, and it stays there for 20 clocks.
  - Pulse reset → t_state=000001, halt=0.
- Freeze: drop input_run at T2 for 3 clocks.
  - t_state holds 000010, pc_inc=0.
  - Raise input_run → pc_inc=1 for exactly one cycle, then T3.
- Invariants:
  - Random opcodes (including undefined 0101 → T4–T6 all-zero) over 500 cycles.
  - Assert that at most one bus driver is active and that exactly one t_state bit is set when not halted.
